// File: rtl/led_fade_pkg.sv
// Shared types and default constants for the LED PWM fader.
package led_fade_pkg;

  localparam int unsigned DEF_PWM_BITS  = 8;
  localparam int unsigned DEF_FADE_STEP = 1;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RISING  = 2'd1,
    ST_ON      = 2'd2,
    ST_FALLING = 2'd3
  } ch_state_t;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: fade state, brightness level, duty mapping and PWM compare.
// Optional gamma duty curve is enabled with `define LED_PWM_FADER_GAMMA_EN.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS  = DEF_PWM_BITS,
  parameter int unsigned FADE_STEP = DEF_FADE_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                target,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                active
);

  localparam logic [PWM_BITS:0] MAX_EXT  = {1'b0, {PWM_BITS{1'b1}}};
  localparam logic [PWM_BITS:0] STEP_EXT = (PWM_BITS+1)'(FADE_STEP);

  ch_state_t           state, state_nx;
  logic [PWM_BITS-1:0] level, level_nx;
  logic [PWM_BITS:0]   sum, diff;
  logic [PWM_BITS-1:0] duty;
  logic                full_on;

  // State and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OFF;
      level <= '0;
    end else begin
      state <= state_nx;
      level <= level_nx;
    end
  end

  // Next state: a tick steps toward the current target (one bit of headroom
  // catches overflow/borrow so saturation never wraps); otherwise only the
  // fade direction follows the target.
  always_comb begin
    state_nx = state;
    level_nx = level;
    sum      = {1'b0, level} + STEP_EXT;
    diff     = {1'b0, level} - STEP_EXT;
    if (tick) begin
      if (target) begin
        if (sum >= MAX_EXT) begin
          level_nx = '1;
          state_nx = ST_ON;
        end else begin
          level_nx = sum[PWM_BITS-1:0];
          state_nx = ST_RISING;
        end
      end else begin
        if (diff[PWM_BITS] || diff == '0) begin
          level_nx = '0;
          state_nx = ST_OFF;
        end else begin
          level_nx = diff[PWM_BITS-1:0];
          state_nx = ST_FALLING;
        end
      end
    end else if (target && (state == ST_OFF || state == ST_FALLING)) begin
      state_nx = ST_RISING;
    end else if (!target && (state == ST_ON || state == ST_RISING)) begin
      state_nx = ST_FALLING;
    end
  end

`ifdef LED_PWM_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq      = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
  assign duty    = PWM_BITS'(sq >> PWM_BITS);
  assign full_on = (level == '1);
`else
  assign duty    = level;
  assign full_on = 1'b0;
`endif

  assign active = (state == ST_RISING) || (state == ST_FALLING);

  // Registered PWM drive; ON/OFF override the compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 1'b0;
    end else begin
      case (state)
        ST_ON:   led <= 1'b1;
        ST_OFF:  led <= 1'b0;
        default: led <= full_on | (pwm_cnt < duty);
      endcase
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// Four-channel LED PWM fader: shared PWM counter, per-channel faders, busy flag.
// Gamma duty curve per channel is selected with `define LED_PWM_FADER_GAMMA_EN.
module led_pwm_fader
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS  = DEF_PWM_BITS,
  parameter int unsigned FADE_STEP = DEF_FADE_STEP
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_pattern,
  input  logic       i_tick,
  output logic [3:0] o_leds,
  output logic       o_busy
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [3:0]          active;

  // Free-running PWM counter shared by all channels.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) pwm_cnt <= '0;
    else            pwm_cnt <= pwm_cnt + 1'b1;
  end

  genvar k;
  for (k = 0; k < 4; k++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .clk     (i_clk),
      .rst_n   (i_reset_n),
      .target  (i_pattern[k]),
      .tick    (i_tick),
      .pwm_cnt (pwm_cnt),
      .led     (o_leds[k]),
      .active  (active[k])
    );
  end

  // Busy while any channel is mid-fade.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_busy <= 1'b0;
    else            o_busy <= |active;
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader (PWM_BITS=4, FADE_STEP=4). Brightness is
// observed as the number of high o_leds samples over one 16-cycle PWM period.
module tb_led_pwm_fader;

  localparam int PB   = 4;
  localparam int FS   = 4;
  localparam int MAXL = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic       tick = 1'b0;
  logic [3:0] leds;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int cnt[4];

  always #5 clk = ~clk;

  led_pwm_fader #(
    .PWM_BITS  (PB),
    .FADE_STEP (FS)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_pattern (pattern),
    .i_tick    (tick),
    .o_leds    (leds),
    .o_busy    (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // High samples per 16-cycle period for a given level; on = channel in ON.
  function automatic int exp_count(int level, bit on);
    if (on) return 16;
`ifdef LED_PWM_FADER_GAMMA_EN
    if (level == MAXL) return 16;
    return (level * level) >> PB;
`else
    return level;
`endif
  endfunction

  task automatic check(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_check(string tag, int obs);
    int e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=%0d expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  // Tick high for exactly one rising edge; returns at the negedge after it.
  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic measure();
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    repeat (16) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) cnt[k] += int'(leds[k]);
    end
  endtask

  initial begin
    int lv[3];
    lv[0] = 4; lv[1] = 8; lv[2] = 12;

    // Reset state
    cyc(3);
    check("reset_leds", int'(leds), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;

    // All targets off: nothing lights, never busy
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outputs", int'({busy, leds}), 0);
    end

    // Fade LED0 up in four ticks
    pattern = 4'b0001;
    cyc(2);
    check("rise_busy", int'(busy), 1);
    exp_q.push_back(exp_count(0, 0));
    measure();
    sb_check("rise_lvl0", cnt[0]);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_count(lv[i], 0));
      do_tick();
      cyc(1);
      measure();
      sb_check("rise_step", cnt[0]);
    end
    check("others_dark", cnt[1] + cnt[2] + cnt[3], 0);
    exp_q.push_back(exp_count(MAXL, 1));
    do_tick();
    cyc(1);
    check("on_busy_low", int'(busy), 0);
    measure();
    sb_check("on_full", cnt[0]);

    // Fall two steps, then reverse mid-fade
    pattern = 4'b0000;
    exp_q.push_back(exp_count(MAXL, 0));
    cyc(2);
    check("fall_busy", int'(busy), 1);
    measure();
    sb_check("fall_lvl15", cnt[0]);
    exp_q.push_back(exp_count(11, 0));
    do_tick(); cyc(1); measure();
    sb_check("fall_11", cnt[0]);
    exp_q.push_back(exp_count(7, 0));
    do_tick(); cyc(1); measure();
    sb_check("fall_7", cnt[0]);
    pattern = 4'b0001;
    cyc(2);
    exp_q.push_back(exp_count(11, 0));
    do_tick(); cyc(1); measure();
    sb_check("reverse_11", cnt[0]);
    check("reverse_busy", int'(busy), 1);

    // Back to OFF, last step saturates 3 -> 0
    pattern = 4'b0000;
    exp_q.push_back(exp_count(7, 0));
    exp_q.push_back(exp_count(3, 0));
    exp_q.push_back(exp_count(0, 0));
    for (int i = 0; i < 3; i++) begin
      do_tick(); cyc(1); measure();
      sb_check("fall_to_off", cnt[0]);
    end
    check("off_busy", int'(busy), 0);

    // Target change and tick on the same cycle, all channels
    pattern = 4'b1111;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("same_cycle_busy_lag", int'(busy), 0);
    @(negedge clk);
    check("same_cycle_busy", int'(busy), 1);
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_count(4, 0));
    measure();
    for (int k = 0; k < 4; k++) sb_check("all_lvl4", cnt[k]);

    // Reverse with tick on the same cycle: 4 -> 0, straight to OFF
    pattern = 4'b0000;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cyc(1);
    check("rev_tick_busy", int'(busy), 0);
    measure();
    check("rev_tick_dark", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);

    // Asynchronous reset mid-fade at level 8
    pattern = 4'b0001;
    do_tick();
    do_tick();
    cyc(1);
    exp_q.push_back(exp_count(8, 0));
    measure();
    sb_check("pre_reset_lvl8", cnt[0]);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_leds", int'(leds), 0);
    check("async_rst_busy", int'(busy), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    check("post_rst_busy", int'(busy), 1);
    exp_q.push_back(exp_count(0, 0));
    measure();
    sb_check("post_rst_lvl0", cnt[0]);
    exp_q.push_back(exp_count(4, 0));
    do_tick(); cyc(1); measure();
    sb_check("post_rst_lvl4", cnt[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 The block SHALL have parameter PWM_BITS, default 8, giving the PWM counter and brightness level width; MAX = 2^PWM_BITS-1.
REQ-002 The block SHALL have parameter FADE_STEP, default 1, giving the level increment/decrement applied per i_tick.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_pattern, input, 4 bits: per-LED on/off target from the upstream pattern sequencer.
REQ-006 The block SHALL have port i_tick, input, 1 bit: single-cycle fade-step strobe from the clock divider.
REQ-007 The block SHALL have port o_leds, output, 4 bits: registered PWM drive, one bit per LED.
REQ-008 The block SHALL have port o_busy, output, 1 bit: registered; high while any channel is RISING or FALLING.

Function
REQ-009 The block SHALL run a free-running PWM_BITS counter, incrementing every cycle and wrapping MAX->0, shared by all channels.
REQ-010 Each channel SHALL hold a PWM_BITS level and a state from {OFF, RISING, ON, FALLING}.
REQ-011 A non-tick cycle SHALL leave level unchanged; target bit 1 in OFF/FALLING SHALL move the state to RISING next cycle, and target 0 in ON/RISING SHALL move it to FALLING next cycle.
REQ-012 On an i_tick cycle, the state SHALL advance by one level step in the direction of the current target bit.
REQ-013 When the target is 1, that step SHALL set level = min(level+FADE_STEP, MAX), entering ON when MAX is reached.
REQ-014 When the target is 0, that step SHALL set level = max(level-FADE_STEP, 0), entering OFF when 0 is reached.
REQ-015 A target change and i_tick in the same cycle SHALL step toward the new target in that cycle.
REQ-016 A target change mid-fade SHALL reverse direction from the current level, with no jump.
REQ-017 Level arithmetic SHALL use PWM_BITS+1 bits internally, with no wrap on saturation.
REQ-018 o_leds[k] SHALL be set in the cycle after (pwm_cnt < duty_k), giving 1 cycle latency.
REQ-019 ON SHALL force o_leds[k]=1 constantly, and OFF SHALL force it to 0.
REQ-020 Without gamma, duty_k SHALL equal level_k.
REQ-021 i_tick held high for consecutive cycles SHALL step once per cycle.

Reset
REQ-022 Asserting i_reset_n low SHALL immediately clear pwm counter, all levels to 0, all states to OFF, o_leds to 4'b0000 and o_busy to 0, including mid-fade.
REQ-023 After reset deassertion, channels whose target is 1 SHALL enter RISING on the first clock edge.

Configuration
REQ-024 When LED_PWM_FADER_GAMMA_EN is defined, duty_k SHALL be (level_k*level_k)>>PWM_BITS, with level MAX still forcing full on.
REQ-025 When LED_PWM_FADER_GAMMA_EN is undefined, duty_k SHALL equal level_k and no multiplier SHALL be synthesised.

Structure
REQ-026 Package led_fade_pkg SHALL hold the channel state encoding (OFF=2'd0, RISING=2'd1, ON=2'd2, FALLING=2'd3) and the default PWM_BITS/FADE_STEP constants.
REQ-027 Sub-module led_fade_channel SHALL implement one channel's state, level, duty mapping and compare, and SHALL be instantiated 4 times.
REQ-028 The top level SHALL hold the shared PWM counter and the o_busy OR-reduction register.

Verification (PWM_BITS=4, FADE_STEP=4, MAX=15)
REQ-029 Reset then i_pattern=4'b0000, 100 cycles -> o_leds=0, o_busy=0 throughout.
REQ-030 i_pattern=4'b0001 then 4 ticks -> LED0 levels 4,8,12,15; LED0 high 4/16 cycles per PWM period at level 4; ON after 4th tick; o_busy falls.
REQ-031 From ON, i_pattern=0 then 2 ticks, then i_pattern=1 then 1 tick -> levels 11,7,11 with no discontinuity; final state RISING.
REQ-032 i_pattern=4'b1111 with i_tick on the same cycle -> all levels 4 after that edge; o_busy=1 the following cycle.
REQ-033 i_reset_n low at level 8 while RISING -> o_leds=0, o_busy=0 before the next clock edge; after release with target 1, levels restart from 0.
REQ-034 With LED_PWM_FADER_GAMMA_EN defined, level 8 -> duty 4 (4/16 high); level 15 -> constant high.
